// File: rtl/ccb_pkg.sv
// Shared CCB constants: calibration sequencer state encoding, calibration type
// codes and the majority voters used by the triplicated registers.
package ccb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAITBC0 = 3'd1,
        PULSE   = 3'd2,
        DELAY   = 3'd3,
        TRIG    = 3'd4,
        HOLD    = 3'd5
    } cal_state_e;

    typedef enum logic [1:0] {
        INJ = 2'd0,
        PED = 2'd1,
        EXT = 2'd2
    } cal_type_e;

    function automatic logic [7:0] maj8(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic cal_state_e maj_st(input cal_state_e a, input cal_state_e b,
                                          input cal_state_e c);
        return cal_state_e'((a & b) | (a & c) | (b & c));
    endfunction

endpackage

// File: rtl/cal_dcnt.sv
// 8-bit loadable down-counter that parks at zero; optionally triplicated with
// bitwise majority voting so a single upset cannot shorten a phase.
module cal_dcnt
    import ccb_pkg::*;
#(
    parameter int TMR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld,
    input  logic [7:0] ld_val,
    output logic       zero
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    generate
        if (TMR != 0) begin : g_tmr
            logic [7:0] cnt_r_q [3];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_r_q[0] <= 8'd0;
                    cnt_r_q[1] <= 8'd0;
                    cnt_r_q[2] <= 8'd0;
                end else begin
                    cnt_r_q[0] <= cnt_d;
                    cnt_r_q[1] <= cnt_d;
                    cnt_r_q[2] <= cnt_d;
                end
            end
            assign cnt_q = maj8(cnt_r_q[0], cnt_r_q[1], cnt_r_q[2]);
        end else begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= 8'd0;
                else        cnt_q <= cnt_d;
            end
        end
    endgenerate

    assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/cal_seq.sv
// Calibration sequencer: arbitrates TTC calibration requests, plays the
// pulse / delay / trigger / holdoff sequence and counts discarded requests.
module cal_seq
    import ccb_pkg::*;
#(
    parameter int TMR     = 0,
    parameter int PLS_W   = 4,
    parameter int HOLDOFF = 16
) (
    input  logic       CLKCMS,
    input  logic       RSTN,
    input  logic       START_TRG,
    input  logic       STOP_TRG,
    input  logic       L1ASRST,
    input  logic       BC0,
    input  logic [2:0] TTCCAL,
    input  logic       ALIGN_BC0,
    input  logic [7:0] CAL_DLY,
    output logic       RUN,
    output logic       BUSY,
    output logic       INJPLS,
    output logic       EXTPLS,
    output logic       CAL_L1A,
    output logic [7:0] DROP_CNT
);

    localparam logic [7:0] PLS_LD  = 8'(PLS_W - 1);
    localparam logic [7:0] HOLD_LD = 8'(HOLDOFF - 1);

    // Reset asserts immediately but releases two clocks later, on our edge.
    logic rst_meta_q, rst_sync_q, rst_n;
    always_ff @(posedge CLKCMS or negedge RSTN) begin
        if (!RSTN) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end
    assign rst_n = rst_sync_q;

    cal_state_e state_q, state_d;
    cal_type_e  typ_q, typ_d, pend_type_q, pend_type_d, win_type, go_type;
    logic [7:0] dly_q, dly_d, drop_q, drop_d, go_dly, cnt_ld_val;
    logic       run_q, run_d, pend_vld_q, pend_vld_d;
    logic       busy_q, busy_d, inj_q, inj_d, ext_q, ext_d, l1a_q, l1a_d;
    logic       req_vld, go, to_dly, cnt_ld, cnt_zero;
    logic [1:0] n_req, drop_add;
    logic [8:0] drop_sum;

    always_comb begin
        req_vld  = run_q && !L1ASRST && (TTCCAL != 3'b000);
        win_type = TTCCAL[0] ? INJ : (TTCCAL[1] ? PED : EXT);
        n_req    = {1'b0, TTCCAL[0]} + {1'b0, TTCCAL[1]} + {1'b0, TTCCAL[2]};
    end

    always_comb begin
        state_d     = state_q;
        typ_d       = typ_q;
        dly_d       = dly_q;
        pend_vld_d  = pend_vld_q;
        pend_type_d = pend_type_q;
        cnt_ld      = 1'b0;
        cnt_ld_val  = 8'd0;
        go          = 1'b0;
        to_dly      = 1'b0;
        go_type     = typ_q;
        go_dly      = dly_q;
        drop_add    = req_vld ? (n_req - 2'd1) : 2'd0;
        run_d       = STOP_TRG ? 1'b0 : (START_TRG ? 1'b1 : run_q);

        // A pending request always launches before a new one; the new one
        // then takes the freed slot.
        if (state_q == IDLE) begin
            if (pend_vld_q || req_vld) begin
                go_type    = pend_vld_q ? pend_type_q : win_type;
                go_dly     = CAL_DLY;
                typ_d      = go_type;
                dly_d      = CAL_DLY;
                pend_vld_d = pend_vld_q && req_vld;
                if (pend_vld_q && req_vld) pend_type_d = win_type;
                if (ALIGN_BC0 && !BC0) state_d = WAITBC0;
                else                   go = 1'b1;
            end
        end else if (req_vld) begin
            if (!pend_vld_q) begin
                pend_vld_d  = 1'b1;
                pend_type_d = win_type;
            end else begin
                drop_add = drop_add + 2'd1;
            end
        end

        case (state_q)
            WAITBC0: if (BC0) go = 1'b1;
            PULSE:   if (cnt_zero) to_dly = 1'b1;
            DELAY:   if (cnt_zero) state_d = TRIG;
            TRIG: begin
                state_d    = HOLD;
                cnt_ld     = 1'b1;
                cnt_ld_val = HOLD_LD;
            end
            HOLD:    if (cnt_zero) state_d = IDLE;
            default: ;
        endcase

        if (go) begin
            if (go_type == PED) begin
                to_dly = 1'b1;
            end else begin
                state_d    = PULSE;
                cnt_ld     = 1'b1;
                cnt_ld_val = PLS_LD;
            end
        end
        if (to_dly) begin
            if (go_dly == 8'd0) begin
                state_d = TRIG;
            end else begin
                state_d    = DELAY;
                cnt_ld     = 1'b1;
                cnt_ld_val = go_dly - 8'd1;
            end
        end

        if (STOP_TRG) pend_vld_d = 1'b0;
        if (L1ASRST) begin
            state_d    = IDLE;
            pend_vld_d = 1'b0;
        end

        drop_sum = {1'b0, drop_q} + {7'd0, drop_add};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

        // Outputs come straight from next-state so every one is a flop.
        busy_d = (state_d != IDLE) || pend_vld_d;
        inj_d  = (state_d == PULSE) && (typ_d == INJ);
        ext_d  = (state_d == PULSE) && (typ_d == EXT);
        l1a_d  = (state_d == TRIG);
    end

    generate
        if (TMR != 0) begin : g_st_tmr
            cal_state_e st_r_q [3];
            always_ff @(posedge CLKCMS or negedge rst_n) begin
                if (!rst_n) begin
                    st_r_q[0] <= IDLE;
                    st_r_q[1] <= IDLE;
                    st_r_q[2] <= IDLE;
                end else begin
                    st_r_q[0] <= state_d;
                    st_r_q[1] <= state_d;
                    st_r_q[2] <= state_d;
                end
            end
            assign state_q = maj_st(st_r_q[0], st_r_q[1], st_r_q[2]);
        end else begin : g_st_one
            always_ff @(posedge CLKCMS or negedge rst_n) begin
                if (!rst_n) state_q <= IDLE;
                else        state_q <= state_d;
            end
        end
    endgenerate

    always_ff @(posedge CLKCMS or negedge rst_n) begin
        if (!rst_n) begin
            typ_q       <= INJ;
            dly_q       <= 8'd0;
            pend_vld_q  <= 1'b0;
            pend_type_q <= INJ;
            drop_q      <= 8'd0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            inj_q       <= 1'b0;
            ext_q       <= 1'b0;
            l1a_q       <= 1'b0;
        end else begin
            typ_q       <= typ_d;
            dly_q       <= dly_d;
            pend_vld_q  <= pend_vld_d;
            pend_type_q <= pend_type_d;
            drop_q      <= drop_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            inj_q       <= inj_d;
            ext_q       <= ext_d;
            l1a_q       <= l1a_d;
        end
    end

    cal_dcnt #(.TMR(TMR)) u_dcnt (
        .clk    (CLKCMS),
        .rst_n  (rst_n),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_val),
        .zero   (cnt_zero)
    );

    assign RUN      = run_q;
    assign BUSY     = busy_q;
    assign INJPLS   = inj_q;
    assign EXTPLS   = ext_q;
    assign CAL_L1A  = l1a_q;
    assign DROP_CNT = drop_q;

endmodule
